// File: rtl/mbc_control_sequencer.sv
// mbc_control_sequencer: fetch/decode/indirect/execute sequencer driving MBC register strobes
module mbc_control_sequencer #(
    parameter int SC_WIDTH    = 3,
    parameter int EXEC_CYCLES = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [7:0]          ir_data_i,
    output logic [2:0]          bus_sel_o,
    output logic                mem_read_o,
    output logic                pc_increment_o,
    output logic                pc_write_enable_o,
    output logic                pc_clear_o,
    output logic                ar_write_enable_o,
    output logic                ir_write_enable_o,
    output logic [2:0]          opcode_o,
    output logic                exec_valid_o,
    output logic [SC_WIDTH-1:0] exec_step_o,
    output logic [SC_WIDTH-1:0] sc_o,
    output logic                halted_o
);
    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
    localparam logic [SC_WIDTH-1:0] LAST = SC_WIDTH'(3 + EXEC_CYCLES);
    state_t                state_q, state_d;
    logic [SC_WIDTH-1:0]   sc_q, sc_d;
    logic [2:0]            opcode_q, opcode_d;
    logic                  ind_q, ind_d;
    logic                  t0, t1, t2, t3, ex;
    assign t0 = state_q == FETCH && sc_q == SC_WIDTH'(0);
    assign t1 = state_q == FETCH && sc_q == SC_WIDTH'(1);
    assign t2 = state_q == FETCH && sc_q == SC_WIDTH'(2);
    assign t3 = state_q == FETCH && sc_q == SC_WIDTH'(3) && ind_q;
    assign ex = state_q == FETCH && sc_q >= SC_WIDTH'(4);
    // state, sequence count and latched instruction fields
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sc_q     <= '0;
            opcode_q <= '0;
            ind_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sc_q     <= sc_d;
            opcode_q <= opcode_d;
            ind_q    <= ind_d;
        end
    end
    // next state: SC advances in FETCH, cleared after the last execute cycle or on HALT
    always_comb begin
        state_d  = state_q;
        sc_d     = '0;
        opcode_d = t2 ? ir_data_i[6:4] : opcode_q;
        ind_d    = t2 ? ir_data_i[7] : ind_q;
        if (state_q == FETCH) begin
            sc_d = sc_q == LAST ? '0 : sc_q + SC_WIDTH'(1);
            if (t2 && ir_data_i[6:4] == 3'b111) begin
                state_d = HALTED;
                sc_d    = '0;
            end
        end else if (start_i) begin
            state_d = FETCH;
        end
    end
    // control strobes decoded from state and SC; only one bus load per cycle
    always_comb begin
        bus_sel_o         = t0 ? 3'd1 : t1 ? 3'd4 : t2 ? 3'd3 : t3 ? 3'd4 : 3'd0;
        mem_read_o        = t1 | t3;
        pc_increment_o    = t1;
        pc_write_enable_o = 1'b0;
        pc_clear_o        = state_q == IDLE && start_i && !rst_i;
        ar_write_enable_o = t0 | t2 | t3;
        ir_write_enable_o = t1;
        exec_valid_o      = ex;
        exec_step_o       = ex ? sc_q - SC_WIDTH'(4) : '0;
        halted_o          = state_q == HALTED;
        opcode_o          = opcode_q;
        sc_o              = sc_q;
    end
endmodule

// File: tb/tb_mbc_control_sequencer.sv
// tb_mbc_control_sequencer: directed checks of the MBC control sequencer
module tb_mbc_control_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] ir_data_i = 8'h00;
    logic [2:0] bus_sel_o, opcode_o, exec_step_o, sc_o;
    logic       mem_read_o, pc_increment_o, pc_write_enable_o, pc_clear_o;
    logic       ar_write_enable_o, ir_write_enable_o, exec_valid_o, halted_o;
    int         passed = 0;
    int         total = 0;
    localparam logic [10:0] NONE = {3'd0, 8'b0000_0000};
    localparam logic [10:0] T0   = {3'd1, 8'b0000_1000};
    localparam logic [10:0] T1   = {3'd4, 8'b1100_0100};
    localparam logic [10:0] T2   = {3'd3, 8'b0000_1000};
    localparam logic [10:0] IND  = {3'd4, 8'b1000_1000};
    localparam logic [10:0] EX   = {3'd0, 8'b0000_0010};
    localparam logic [10:0] HLT  = {3'd0, 8'b0000_0001};
    localparam logic [10:0] CLR  = {3'd0, 8'b0001_0000};

    mbc_control_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ir_data_i(ir_data_i),
        .bus_sel_o(bus_sel_o), .mem_read_o(mem_read_o), .pc_increment_o(pc_increment_o),
        .pc_write_enable_o(pc_write_enable_o), .pc_clear_o(pc_clear_o),
        .ar_write_enable_o(ar_write_enable_o), .ir_write_enable_o(ir_write_enable_o),
        .opcode_o(opcode_o), .exec_valid_o(exec_valid_o), .exec_step_o(exec_step_o),
        .sc_o(sc_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [10:0] outs();
        return {bus_sel_o, mem_read_o, pc_increment_o, pc_write_enable_o, pc_clear_o,
                ar_write_enable_o, ir_write_enable_o, exec_valid_o, halted_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic cyc(input string tag, input logic [10:0] o, input int sc);
        chk({tag, "_outs"}, 32'(outs()), 32'(o));
        chk({tag, "_sc"}, 32'(sc_o), 32'(sc));
    endtask

    initial begin
        tick();
        tick();
        cyc("reset", NONE, 0);
        chk("reset_op", 32'(opcode_o), 0);
        rst_i = 1'b0;
        tick();
        cyc("idle", NONE, 0);
        start_i = 1'b1;
        ir_data_i = 8'h25;
        #1 cyc("idle_start", CLR, 0);
        tick();
        start_i = 1'b0;
        cyc("d_t0", T0, 0);
        tick();
        cyc("d_t1", T1, 1);
        tick();
        cyc("d_t2", T2, 2);
        tick();
        cyc("d_t3", NONE, 3);
        chk("d_op", 32'(opcode_o), 32'h2);
        start_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            cyc("d_ex", EX, 4 + k);
            chk("d_step", 32'(exec_step_o), 32'(k));
        end
        start_i = 1'b0;
        tick();
        cyc("d_wrap", T0, 0);
        ir_data_i = 8'hB3;
        tick();
        cyc("i_t1", T1, 1);
        tick();
        cyc("i_t2", T2, 2);
        tick();
        cyc("i_t3", IND, 3);
        chk("i_op", 32'(opcode_o), 32'h3);
        for (int k = 0; k < 3; k++) begin
            tick();
            cyc("i_ex", EX, 4 + k);
            chk("i_step", 32'(exec_step_o), 32'(k));
        end
        tick();
        cyc("i_wrap", T0, 0);
        ir_data_i = 8'h70;
        tick();
        cyc("h_t1", T1, 1);
        tick();
        cyc("h_t2", T2, 2);
        for (int k = 0; k < 20; k++) begin
            tick();
            cyc("halted", HLT, 0);
        end
        chk("h_op", 32'(opcode_o), 32'h7);
        start_i = 1'b1;
        #1 cyc("h_start", HLT, 0);
        tick();
        start_i = 1'b0;
        ir_data_i = 8'h25;
        cyc("resume_t0", T0, 0);
        tick();
        cyc("r_t1", T1, 1);
        #1 rst_i = 1'b1;
        #1 cyc("rst_mid", NONE, 0);
        chk("rst_op", 32'(opcode_o), 0);
        tick();
        rst_i = 1'b0;
        tick();
        cyc("post_rst", NONE, 0);
        tick();
        cyc("post_rst2", NONE, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
